vga_vram_responder: RTL and testbench
=====================================

// Module: vga_vram_responder
// PURPOSE
//   Serves the display's VRAM read interface (vram_req/vram_addr -> vram_ready/vram_data) from on-chip VRAM.
//   Arbitrates one single-port RAM between display reads (priority) and a CPU read/write port; all logic runs on vga_clk.
//   Sits between the display scanout engine and the bus-side CDC bridge that drives the cpu_* port.
// PARAMETERS
//   ADDR_WIDTH   15     word address width, both ports
//   DATA_WIDTH   32     word width, both ports
//   DEPTH        21504  implemented words (768x896 px / 32 bpw); addresses >= DEPTH are out of range
//   HOLD_CYCLES  2      cycles after a vram_ready pulse during which vram_req is ignored (display req is registered)
// PORTS
//   vga_clk    in   1           clock
//   reset      in   1           asynchronous, active-high
//   vram_req   in   1           display read request, level; may stay high up to 2 cycles after vram_ready
//   vram_addr  in   ADDR_WIDTH  display word address, sampled at grant
//   vram_ready out  1           one-cycle pulse: vram_data valid
//   vram_data  out  DATA_WIDTH  display read data; held stable until next vram_ready
//   cpu_req    in   1           CPU access request, level, held until cpu_ack
//   cpu_we     in   1           1=write, 0=read; sampled at grant
//   cpu_addr   in   ADDR_WIDTH  CPU word address, sampled at grant
//   cpu_wdata  in   DATA_WIDTH  write data, sampled at grant
//   cpu_ack    out  1           one-cycle pulse: access complete (write committed / cpu_rdata valid)
//   cpu_rdata  out  DATA_WIDTH  CPU read data; held stable until next read ack
// BEHAVIOUR
//   - Reset values: vram_ready=0, cpu_ack=0, vram_data=0, cpu_rdata=0, pipeline empty, hold counter=0. RAM contents NOT reset.
//   - Grant stage (cycle T), one grant per cycle max:
//       display granted if vram_req && !disp_busy; else CPU granted if cpu_req && !cpu_busy.
//       Display always wins a simultaneous request; CPU may use any cycle display is not granted (incl. hold window).
//   - Grant drives RAM addr/we/wdata at edge ending T; owner tag (DISP/CPU/NONE) pipelined alongside.
//   - T+1: RAM read data out (1-cycle BRAM latency); registered into vram_data or cpu_rdata per tag at edge ending T+1.
//   - T+2: vram_ready or cpu_ack high for exactly one cycle. Fixed latency grant->response = 2 cycles.
//   - disp_busy: set at display grant, cleared HOLD_CYCLES cycles after the vram_ready cycle (default: next display grant
//     no earlier than T+5). Guarantees one response per display request despite registered req.
//   - cpu_busy: set at CPU grant, cleared after the cpu_ack cycle (next CPU grant no earlier than T+3).
//   - Worst-case display wait from vram_req high to grant: 0 cycles (priority); display never delayed by CPU.
//   - Writes: RAM written at edge ending T for CPU write grant; a display read of same addr granted later sees new data.
//     Write-then-read same addr by CPU: second access sees written value.
//   - Out-of-range addr (>= DEPTH): reads return 0, writes dropped; response/ack still issued at T+2.
//   - CPU read returning data leaves vram_data untouched and vice versa.
//   - Reset mid-operation: in-flight grants discarded, no ready/ack issued for them; write granted in same cycle reset
//     asserts is not committed. After release, first grant possible on first clock edge.
//   - Never drives vram_ready and cpu_ack for the same grant; both may be high in the same cycle only for different grants
//     (not possible at 1 grant/cycle -> at most one of them high per cycle).
// STRUCTURE
//   - Shared package vga_pkg: VRAM_ADDR_WIDTH, VRAM_DATA_WIDTH, VRAM_DEPTH, BOX_WIDTH/BOX_HEIGHT constants,
//     owner tag enum {OWN_NONE, OWN_DISP, OWN_CPU}.
//   - Sub-module vram_bram: single-port sync RAM, DEPTH x DATA_WIDTH, 1-cycle read latency, write-first.
//   - Top: grant logic, 2-stage tag/pipeline regs, disp_busy hold counter, cpu_busy flag, out-of-range mask.
// TESTING
//   1 Reset: hold reset 3 cycles with vram_req=cpu_req=1 -> vram_ready=cpu_ack=0 throughout; first grant after release.
//   2 CPU write 0xDEADBEEF @0x0010, then display req @0x0010 -> vram_ready exactly 2 cycles after grant, vram_data=0xDEADBEEF.
//   3 vram_req held 4 cycles (mimic registered req) -> exactly one vram_ready pulse; next grant not before grant+5.
//   4 vram_req and cpu_req (read @0x0020) rise same cycle -> display granted T, CPU granted T+1; ready T+2, ack T+3.
//   5 CPU write @21504 (out of range) -> ack issued, RAM unchanged; CPU read @21504 -> cpu_rdata=0.
//   6 Assert reset one cycle after display grant -> no vram_ready; vram_data=0; subsequent request served normally.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VRAM constants and the owner tag carried down the read pipeline.
package vga_pkg;

  localparam int VRAM_ADDR_WIDTH  = 15;
  localparam int VRAM_DATA_WIDTH  = 32;
  localparam int BOX_WIDTH        = 768;
  localparam int BOX_HEIGHT       = 896;
  localparam int VRAM_DEPTH       = (BOX_WIDTH * BOX_HEIGHT) / VRAM_DATA_WIDTH;
  localparam int VRAM_HOLD_CYCLES = 2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

endpackage

// File: rtl/vram_bram.sv
// Single-port synchronous RAM with one cycle of read latency; a write returns the new word.
module vram_bram #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 21504
) (
  input  logic                  vga_clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

  // Write-first RAM port: caller guarantees addr < DEPTH
  always_ff @(posedge vga_clk) begin
    if (en) begin
      if (we) begin
        mem_r[addr] <= wdata;
        rdata       <= wdata;
      end else begin
        rdata <= mem_r[addr];
      end
    end
  end

endmodule

// File: rtl/vga_vram_responder.sv
// Arbitrates the VRAM between display scanout reads (priority) and a CPU read/write port
// with a fixed two-cycle grant-to-response latency.
module vga_vram_responder
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH  = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = VRAM_DATA_WIDTH,
  parameter int DEPTH       = VRAM_DEPTH,
  parameter int HOLD_CYCLES = VRAM_HOLD_CYCLES
) (
  input  logic                  vga_clk,
  input  logic                  reset,
  input  logic                  vram_req,
  input  logic [ADDR_WIDTH-1:0] vram_addr,
  output logic                  vram_ready,
  output logic [DATA_WIDTH-1:0] vram_data,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ack,
  output logic [DATA_WIDTH-1:0] cpu_rdata
);

  localparam int CW = $clog2(HOLD_CYCLES + 2);

  logic                  disp_busy_r;
  logic                  cpu_busy_r;
  logic [CW-1:0]         hold_cnt_r;
  owner_t                tag1_r;
  logic                  oor1_r;
  logic                  we1_r;

  logic                  grant_disp_s;
  logic                  grant_cpu_s;
  owner_t                tag0_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [ADDR_WIDTH-1:0] ram_addr_s;
  logic                  in_range_s;
  logic                  ram_en_s;
  logic                  ram_we_s;
  logic [DATA_WIDTH-1:0] ram_rdata_s;

  // Grant arbitration; reset blocks grants so a write in a reset cycle never commits
  always_comb begin
    grant_disp_s = 1'b0;
    grant_cpu_s  = 1'b0;
    tag0_s       = OWN_NONE;
    addr_s       = '0;
    if (reset) begin
      grant_disp_s = 1'b0;
    end else if (vram_req && !disp_busy_r) begin
      grant_disp_s = 1'b1;
      tag0_s       = OWN_DISP;
      addr_s       = vram_addr;
    end else if (cpu_req && !cpu_busy_r) begin
      grant_cpu_s  = 1'b1;
      tag0_s       = OWN_CPU;
      addr_s       = cpu_addr;
    end else begin
      tag0_s       = OWN_NONE;
    end
    in_range_s = ({{(32-ADDR_WIDTH){1'b0}}, addr_s} < 32'(DEPTH));
    ram_addr_s = in_range_s ? addr_s : '0;
    ram_en_s   = grant_disp_s || grant_cpu_s;
    ram_we_s   = grant_cpu_s && cpu_we && in_range_s;
  end

  vram_bram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_bram (
    .vga_clk (vga_clk),
    .en      (ram_en_s),
    .we      (ram_we_s),
    .addr    (ram_addr_s),
    .wdata   (cpu_wdata),
    .rdata   (ram_rdata_s)
  );

  // Response pipeline: tag follows RAM latency, data captured one edge before the strobe
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      tag1_r     <= OWN_NONE;
      oor1_r     <= 1'b0;
      we1_r      <= 1'b0;
      vram_ready <= 1'b0;
      cpu_ack    <= 1'b0;
      vram_data  <= '0;
      cpu_rdata  <= '0;
    end else begin
      tag1_r     <= tag0_s;
      oor1_r     <= !in_range_s;
      we1_r      <= grant_cpu_s && cpu_we;
      vram_ready <= (tag1_r == OWN_DISP);
      cpu_ack    <= (tag1_r == OWN_CPU);
      case (tag1_r)
        OWN_DISP: vram_data <= oor1_r ? '0 : ram_rdata_s;
        OWN_CPU: begin
          if (!we1_r) begin
            cpu_rdata <= oor1_r ? '0 : ram_rdata_s;
          end
        end
        default: begin
          vram_data <= vram_data;
        end
      endcase
    end
  end

  // Busy tracking: display stays locked out HOLD_CYCLES beyond its ready pulse
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      disp_busy_r <= 1'b0;
      hold_cnt_r  <= '0;
      cpu_busy_r  <= 1'b0;
    end else begin
      if (grant_disp_s) begin
        disp_busy_r <= 1'b1;
        hold_cnt_r  <= '0;
      end else if (vram_ready) begin
        if (HOLD_CYCLES < 1) begin
          disp_busy_r <= 1'b0;
        end else begin
          hold_cnt_r <= CW'(HOLD_CYCLES);
        end
      end else if (hold_cnt_r != '0) begin
        hold_cnt_r <= hold_cnt_r - CW'(1);
        if (hold_cnt_r == CW'(1)) begin
          disp_busy_r <= 1'b0;
        end
      end
      if (grant_cpu_s) begin
        cpu_busy_r <= 1'b1;
      end else if (cpu_ack) begin
        cpu_busy_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_vram_responder.sv
// Directed bench for vga_vram_responder: arbitration, latency, hold window, range and reset.
module tb_vga_vram_responder;

  logic        vga_clk = 1'b0;
  logic        reset;
  logic        vram_req;
  logic [14:0] vram_addr;
  logic        vram_ready;
  logic [31:0] vram_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic rdy_q;
  logic ack_q;

  vga_vram_responder dut (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .vram_req   (vram_req),
    .vram_addr  (vram_addr),
    .vram_ready (vram_ready),
    .vram_data  (vram_data),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rdata  (cpu_rdata)
  );

  always #5 vga_clk = ~vga_clk;

  // Sample strobes mid-cycle, then advance to just after the next rising edge
  task automatic cyc();
    @(negedge vga_clk);
    rdy_q = vram_ready;
    ack_q = cpu_ack;
    @(posedge vga_clk);
    #1;
  endtask

  task automatic idle();
    vram_req = 1'b0;
    cpu_req  = 1'b0;
    repeat (6) cyc();
  endtask

  // Bounded CPU access; n = cycle index of the ack relative to the request cycle, -1 on timeout
  task automatic cpu_access(input logic we, input logic [14:0] addr, input logic [31:0] wdata,
                            output int n);
    n = -1;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    for (int i = 0; i < 8; i++) begin
      if (n < 0) begin
        cyc();
        if (ack_q) n = i;
      end
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] exp_r;
    logic [3:0] exp_a;
    reset = 1'b1; vram_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    vram_addr = 15'd0; cpu_addr = 15'd0; cpu_wdata = 32'd0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++;
      if (rdy_q !== 1'b0 || ack_q !== 1'b0 || vram_data !== 32'd0 || cpu_rdata !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: ready=%b ack=%b vdata=%h cdata=%h expected 0 0 0 0",
                 i, rdy_q, ack_q, vram_data, cpu_rdata);
      end
    end
    reset = 1'b0;
    exp_r = 4'b0100;
    exp_a = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      vram_req = (i < 3);
      cyc();
      n_tests++;
      if (rdy_q !== exp_r[i] || ack_q !== exp_a[i]) begin
        n_fail++;
        $display("FAIL reset_release cycle %0d: ready=%b ack=%b expected %b %b",
                 i, rdy_q, ack_q, exp_r[i], exp_a[i]);
      end
    end
    idle();
  endtask

  task automatic test_write_display();
    int n;
    cpu_access(1'b1, 15'h0010, 32'hDEADBEEF, n);
    n_tests++;
    if (n !== 2) begin
      n_fail++;
      $display("FAIL write_ack_latency: ack at cycle %0d expected 2", n);
    end
    vram_addr = 15'h0010;
    for (int i = 0; i < 5; i++) begin
      vram_req = (i < 2);
      cyc();
      n_tests++;
      if (rdy_q !== (i == 2)) begin
        n_fail++;
        $display("FAIL disp_latency cycle %0d: ready=%b expected %b", i, rdy_q, (i == 2));
      end
      if (i == 2) begin
        n_tests++;
        if (vram_data !== 32'hDEADBEEF) begin
          n_fail++;
          $display("FAIL disp_read_after_write: vram_data=%h expected deadbeef", vram_data);
        end
      end
    end
    idle();
  endtask

  task automatic test_hold();
    logic [11:0] exp_a;
    logic [11:0] exp_b;
    exp_a = 12'b0000_0000_0100;
    exp_b = 12'b0000_1000_0100;
    vram_addr = 15'h0010;
    for (int i = 0; i < 12; i++) begin
      vram_req = (i < 4);
      cyc();
      n_tests++;
      if (rdy_q !== exp_a[i]) begin
        n_fail++;
        $display("FAIL hold_single cycle %0d: ready=%b expected %b", i, rdy_q, exp_a[i]);
      end
    end
    for (int i = 0; i < 12; i++) begin
      vram_req = (i < 6);
      cyc();
      n_tests++;
      if (rdy_q !== exp_b[i]) begin
        n_fail++;
        $display("FAIL hold_regrant cycle %0d: ready=%b expected %b", i, rdy_q, exp_b[i]);
      end
    end
    idle();
  endtask

  task automatic test_simultaneous();
    int n;
    logic [7:0] exp_r;
    logic [7:0] exp_a;
    cpu_access(1'b1, 15'h0020, 32'h12345678, n);
    exp_r = 8'b0000_0100;
    exp_a = 8'b0000_1000;
    vram_addr = 15'h0010; cpu_addr = 15'h0020; cpu_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      vram_req = (i < 3);
      cpu_req  = (i < 4);
      cyc();
      n_tests++;
      if (rdy_q !== exp_r[i] || ack_q !== exp_a[i]) begin
        n_fail++;
        $display("FAIL simultaneous cycle %0d: ready=%b ack=%b expected %b %b",
                 i, rdy_q, ack_q, exp_r[i], exp_a[i]);
      end
    end
    n_tests++;
    if (vram_data !== 32'hDEADBEEF || cpu_rdata !== 32'h12345678) begin
      n_fail++;
      $display("FAIL simultaneous_data: vdata=%h cdata=%h expected deadbeef 12345678",
               vram_data, cpu_rdata);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    int n_w;
    int n_r;
    cpu_access(1'b1, 15'h0020, 32'hCAFEF00D, n_w);
    cpu_access(1'b0, 15'h0020, 32'h0, n_r);
    n_tests++;
    if (n_w !== 2 || n_r !== 2) begin
      n_fail++;
      $display("FAIL b2b_latency: write ack %0d read ack %0d expected 2 2", n_w, n_r);
    end
    n_tests++;
    if (cpu_rdata !== 32'hCAFEF00D || vram_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL b2b_data: cdata=%h vdata=%h expected cafef00d deadbeef", cpu_rdata, vram_data);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    vram_addr = 15'h0010;
    vram_req  = 1'b1;
    cyc();
    reset = 1'b1; vram_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h0010; cpu_wdata = 32'h99999999;
    cyc();
    n_tests++;
    if (rdy_q !== 1'b0 || vram_data !== 32'd0 || cpu_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_clear: ready=%b vdata=%h cdata=%h expected 0 0 0",
               rdy_q, vram_data, cpu_rdata);
    end
    reset = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_tests++;
      if (rdy_q !== 1'b0 || ack_q !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_discard cycle %0d: ready=%b ack=%b expected 0 0", i, rdy_q, ack_q);
      end
    end
    for (int i = 0; i < 4; i++) begin
      vram_req = (i < 1);
      cyc();
      n_tests++;
      if (rdy_q !== (i == 2)) begin
        n_fail++;
        $display("FAIL reset_mid_resume cycle %0d: ready=%b expected %b", i, rdy_q, (i == 2));
      end
    end
    n_tests++;
    if (vram_data !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL reset_mid_nowrite: vram_data=%h expected deadbeef", vram_data);
    end
    idle();
  endtask

  task automatic test_out_of_range();
    int n;
    cpu_access(1'b1, 15'd0, 32'h11111111, n);
    cpu_access(1'b1, 15'd21504, 32'hFFFFFFFF, n);
    n_tests++;
    if (n !== 2) begin
      n_fail++;
      $display("FAIL oor_write_ack: ack at cycle %0d expected 2", n);
    end
    cpu_access(1'b0, 15'h0020, 32'h0, n);
    n_tests++;
    if (cpu_rdata !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL oor_preload: cpu_rdata=%h expected cafef00d", cpu_rdata);
    end
    cpu_access(1'b0, 15'd21504, 32'h0, n);
    n_tests++;
    if (n !== 2 || cpu_rdata !== 32'd0) begin
      n_fail++;
      $display("FAIL oor_read: ack %0d cpu_rdata=%h expected 2 00000000", n, cpu_rdata);
    end
    cpu_access(1'b0, 15'd0, 32'h0, n);
    n_tests++;
    if (cpu_rdata !== 32'h11111111) begin
      n_fail++;
      $display("FAIL oor_write_dropped: mem[0]=%h expected 11111111", cpu_rdata);
    end
    cpu_access(1'b1, 15'd21503, 32'hA5A5A5A5, n);
    cpu_access(1'b0, 15'd21503, 32'h0, n);
    n_tests++;
    if (cpu_rdata !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL last_word: cpu_rdata=%h expected a5a5a5a5", cpu_rdata);
    end
    vram_addr = 15'd21504;
    for (int i = 0; i < 4; i++) begin
      vram_req = (i < 1);
      cyc();
      n_tests++;
      if (rdy_q !== (i == 2)) begin
        n_fail++;
        $display("FAIL oor_disp cycle %0d: ready=%b expected %b", i, rdy_q, (i == 2));
      end
    end
    n_tests++;
    if (vram_data !== 32'd0) begin
      n_fail++;
      $display("FAIL oor_disp_data: vram_data=%h expected 00000000", vram_data);
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_display();
    test_hold();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_out_of_range();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
